// File: rtl/io_uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter.
// Holds the IO word-address select bits, the CNTL status bit positions,
// the transmit FSM state type and a status-word packing helper.
package io_uart_tx_fifo_pkg;

    // One-hot peripheral select bits within the IO word address.
    localparam int IO_LEDS_BIT      = 0;
    localparam int IO_UART_DAT_BIT  = 1;
    localparam int IO_UART_CNTL_BIT = 2;

    // Status bit positions within the CNTL read word.
    localparam int STAT_PENDING_BIT = 8;
    localparam int STAT_FULL_BIT    = 9;
    localparam int STAT_OVF_BIT     = 10;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Build the CNTL read word; every bit other than the three flags is zero.
    function automatic logic [31:0] pack_status(input logic ovf,
                                                input logic full,
                                                input logic pending);
        logic [31:0] word;
        word                   = '0;
        word[STAT_OVF_BIT]     = ovf;
        word[STAT_FULL_BIT]    = full;
        word[STAT_PENDING_BIT] = pending;
        return word;
    endfunction

endpackage

// File: rtl/io_uart_tx_fifo_fifo.sv
// io_sync_fifo: small synchronous FIFO with show-ahead read.
// Ports:
//   i_clk, i_nrst  clock and asynchronous active-low reset
//   i_push, i_data write side; a push while full is taken only if a pop
//                  happens in the same cycle
//   i_pop          consume the head entry (ignored when empty)
//   o_data         head entry, valid whenever o_empty is 0
//   o_full, o_empty occupancy flags
module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        do_push;
    logic        do_pop;

    assign o_empty = (wr_ptr_reg == rd_ptr_reg);
    assign o_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign do_pop  = i_pop & ~o_empty;
    assign do_push = i_push & (~o_full | do_pop);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage has no reset: contents are only observed behind a valid pointer.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge i_clk) begin
            if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                mem[gi] <= i_data;
            end
        end
    end

    // Show-ahead: the head entry is presented without a read request.
    assign o_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/io_uart_tx_fifo.sv
// io_uart_tx_fifo: memory-mapped buffered UART transmitter (8N1, LSB first).
// Ports:
//   i_clk, i_nrst   clock and asynchronous active-low reset
//   i_io_wordaddr   one-hot IO word select (bit1 = DAT, bit2 = CNTL)
//   i_io_wr         one-cycle write strobe
//   i_io_wdata      write data (DAT: byte in [7:0]; CNTL: [10] clears ovf)
//   o_io_rdata      combinational read data, CNTL = {ovf, full, pending} << 8
//   o_txd           registered serial output, idle high
module io_uart_tx_fifo
    import io_uart_tx_fifo_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 12_000_000,
    parameter int BAUD_RATE   = 1_000_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic [11:0] i_io_wordaddr,
    input  logic        i_io_wr,
    input  logic [31:0] i_io_wdata,
    output logic [31:0] o_io_rdata,
    output logic        o_txd
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic       dat_sel;
    logic       cntl_sel;
    logic       push_req;
    logic       push_ok;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       pending;
    logic       baud_end;

    logic ovf_reg;
    logic ovf_next;

    tx_state_t         state_reg, state_next;
    logic [BAUD_W-1:0] baud_reg,  baud_next;
    logic [2:0]        bit_reg,   bit_next;
    logic [7:0]        shift_reg, shift_next;
    logic              txd_reg,   txd_next;

    // Address bits and write-data bits that this peripheral does not decode.
    logic unused_inputs;
    assign unused_inputs = ^{i_io_wordaddr[11:3], i_io_wordaddr[IO_LEDS_BIT],
                             i_io_wdata[31:11], i_io_wdata[9:8]};

    assign dat_sel  = i_io_wordaddr[IO_UART_DAT_BIT];
    assign cntl_sel = i_io_wordaddr[IO_UART_CNTL_BIT];
    assign push_req = i_io_wr & dat_sel;

    // A full FIFO still takes a byte when the FSM frees a slot this cycle.
    assign push_ok  = push_req & (~fifo_full | pop);

    io_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_push  (push_ok),
        .i_data  (i_io_wdata[7:0]),
        .i_pop   (pop),
        .o_data  (fifo_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // Overflow is sticky; a drop in the same cycle as a clear keeps it set.
    always_comb begin
        ovf_next = ovf_reg;
        if (push_req && !push_ok) begin
            ovf_next = 1'b1;
        end else if (i_io_wr && cntl_sel && i_io_wdata[STAT_OVF_BIT]) begin
            ovf_next = 1'b0;
        end
    end

    assign baud_end = (baud_reg == BAUD_LAST);

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        txd_next   = txd_reg;
        pop        = 1'b0;
        case (state_reg)
            TX_IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_data;
                    state_next = TX_START;
                    txd_next   = 1'b0;
                end
            end
            TX_START: begin
                if (baud_end) begin
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    state_next = TX_DATA;
                    txd_next   = shift_reg[0];
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            TX_DATA: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (bit_reg == 3'd7) begin
                        state_next = TX_STOP;
                        txd_next   = 1'b1;
                    end else begin
                        // Shift right so the next bit to send is always in [1].
                        bit_next   = bit_reg + 3'd1;
                        shift_next = {1'b0, shift_reg[7:1]};
                        txd_next   = shift_reg[1];
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            TX_STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (!fifo_empty) begin
                        // Back-to-back frame: skip IDLE so there is no gap.
                        pop        = 1'b1;
                        shift_next = fifo_data;
                        state_next = TX_START;
                        txd_next   = 1'b0;
                    end else begin
                        state_next = TX_IDLE;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            default: begin
                state_next = TX_IDLE;
                baud_next  = '0;
                txd_next   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_reg <= TX_IDLE;
            baud_reg  <= '0;
            bit_reg   <= 3'd0;
            shift_reg <= 8'd0;
            txd_reg   <= 1'b1;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            txd_reg   <= txd_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign o_txd   = txd_reg;
    assign pending = ~fifo_empty | (state_reg != TX_IDLE);

    assign o_io_rdata = cntl_sel ? pack_status(ovf_reg, fifo_full, pending) : 32'd0;

`ifdef TESTBENCH
    // Echo accepted bytes to the simulator console.
    always @(posedge i_clk) begin
        if (i_nrst && push_ok) begin
            $write("%c", i_io_wdata[7:0]);
        end
    end
`endif

endmodule
